// File: rtl/pakage_unload.sv
// rtl/pakage_unload.sv - DDR read-beat buffer that unpacks 512-bit beats into OUT_W-bit words
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, beat_total           begin a transfer of beat_total beats (honoured in IDLE only)
//   ddr_rd_valid/ready/data     512-bit read beats from the DDR controller
//   out_valid/ready/data/last   unpacked words toward the compute datapath, word 0 = bits [OUT_W-1:0]
//   busy                        high while a transfer is running
//   done                        one-cycle pulse after the final word handshake
module pakage_unload #(
    parameter int DEPTH = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      beat_total,
    input  logic             ddr_rd_valid,
    input  logic [511:0]     ddr_rd_data,
    output logic             ddr_rd_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int WPB = 512 / OUT_W;
    localparam int WIW = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [15:0]      total;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIW-1:0]   word_idx;
    logic [15:0]      beats_in;
    logic [15:0]      beats_out;
    logic             done_r;

    logic [511:0]     mem [DEPTH];
    logic [WPB-1:0][OUT_W-1:0] cur_words;

    logic             run;
    logic             beat_acc;
    logic             word_acc;
    logic             last_word;
    logic             entry_free;

    assign run        = (state == RUN);
    // Ready depends only on the registered occupancy, so a slot freed this
    // cycle becomes visible to the DDR side one cycle later.
    assign ddr_rd_ready = run && (count < CW'(DEPTH)) && (beats_in < total);
    assign out_valid  = run && (count != '0);
    assign last_word  = (word_idx == WIW'(WPB - 1));
    assign out_last   = out_valid && last_word && (beats_out == total - 16'd1);
    assign beat_acc   = ddr_rd_valid && ddr_rd_ready;
    assign word_acc   = out_valid && out_ready;
    assign entry_free = word_acc && last_word;

    // Entry under the read pointer viewed as an array of words; it cannot be
    // overwritten before it is freed, so out_data holds steady while stalled.
    assign cur_words  = mem[rd_ptr];
    assign out_data   = cur_words[word_idx];

    assign busy = run;
    assign done = done_r;

    always_ff @(posedge clk) begin
        if (beat_acc) begin
            mem[wr_ptr] <= ddr_rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            total     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            word_idx  <= '0;
            beats_in  <= '0;
            beats_out <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        total     <= beat_total;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        count     <= '0;
                        word_idx  <= '0;
                        beats_in  <= '0;
                        beats_out <= '0;
                        // An empty transfer completes without ever entering RUN.
                        if (beat_total == 16'd0) begin
                            done_r <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (beat_acc) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        beats_in <= beats_in + 16'd1;
                    end
                    if (word_acc) begin
                        if (last_word) begin
                            word_idx  <= '0;
                            rd_ptr    <= rd_ptr + 1'b1;
                            beats_out <= beats_out + 16'd1;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                    case ({beat_acc, entry_free})
                        2'b10:   count <= count + 1'b1;
                        2'b01:   count <= count - 1'b1;
                        default: count <= count;
                    endcase
                    if (word_acc && out_last) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pakage_unload.sv
// tb/tb_pakage_unload.sv - scoreboard bench for pakage_unload
module tb_pakage_unload;

    localparam int OW  = 32;
    localparam int WPB = 512 / OW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   beat_total = '0;
    logic          ddr_rd_valid = 1'b0;
    logic [511:0]  ddr_rd_data = '0;
    logic          ddr_rd_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    pakage_unload #(.DEPTH(16), .OUT_W(OW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .beat_total   (beat_total),
        .ddr_rd_valid (ddr_rd_valid),
        .ddr_rd_data  (ddr_rd_data),
        .ddr_rd_ready (ddr_rd_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] data;
        bit            last;
    } exp_t;

    exp_t          q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_acc = 0;
    int            ready_mode = 0;
    bit            model_idle = 1'b1;
    bit            exp_done = 1'b0;
    bit            have_hold = 1'b0;
    logic [OW-1:0] hold_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_idle(input string tag);
        chk({tag, "_ddr_rd_ready"}, 64'(ddr_rd_ready), 0);
        chk({tag, "_out_valid"}, 64'(out_valid), 0);
        chk({tag, "_out_last"}, 64'(out_last), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = stalled, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: reference model of the transfer (idle/running, done timing) and
    // the word scoreboard; a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        bit nd;
        exp_t e;
        nd = 1'b0;
        if (!rst_n) begin
            q.delete();
            model_idle = 1'b1;
            exp_done   = 1'b0;
            have_hold  = 1'b0;
        end else begin
            if (done || exp_done) chk("done_pulse", 64'(done), 64'(exp_done));
            chk("busy", 64'(busy), 64'(!model_idle));
            if (have_hold && out_valid) chk("stall_stable", 64'(out_data), 64'(hold_data));
            if (start && model_idle) begin
                if (beat_total == 16'd0) nd = 1'b1;
                else model_idle = 1'b0;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_word", 64'(out_valid), 0);
                end else begin
                    e = q[0];
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (e.last) begin
                            model_idle = 1'b1;
                            nd = 1'b1;
                        end
                    end
                end
            end
            have_hold = out_valid && !out_ready;
            hold_data = out_data;
            exp_done  = nd;
        end
    end

    task automatic start_xfer(input int t);
        beat_total = 16'(t);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beats(input int total, input int vpct, input int stop_after, input bit pat);
        logic [511:0] beat;
        bit acc;
        int guard;
        for (int b = 0; b < stop_after; b++) begin
            for (int k = 0; k < WPB; k++)
                beat[k*OW +: OW] = pat ? 32'(b * WPB + k) : $urandom;
            ddr_rd_data = beat;
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 5000) begin
                ddr_rd_valid = ($urandom_range(0, 99) < vpct);
                @(negedge clk);
                acc = ddr_rd_valid && ddr_rd_ready;
                if (acc) begin
                    n_acc++;
                    for (int k = 0; k < WPB; k++) begin
                        exp_t e;
                        e.data = beat[k*OW +: OW];
                        e.last = (b == total - 1) && (k == WPB - 1);
                        q.push_back(e);
                    end
                end
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) begin
                chk("beat_accept_timeout", 0, 1);
                break;
            end
        end
        ddr_rd_valid = 1'b0;
    endtask

    // Keeps offering surplus beats until done; none may be accepted.
    // Returns in the done cycle, with the number of cycles waited.
    task automatic wait_done(output int cycles);
        bit extra;
        bit got;
        extra = 1'b0;
        got = 1'b0;
        cycles = 0;
        ddr_rd_valid = 1'b1;
        ddr_rd_data = {16{$urandom}};
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                got = 1'b1;
                cycles = i;
                break;
            end
            @(negedge clk);
            if (ddr_rd_ready) extra = 1'b1;
            @(posedge clk);
            #1;
        end
        ddr_rd_valid = 1'b0;
        chk("no_extra_beat", 64'(extra), 0);
        chk("done_seen", 64'(got), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_idle("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outputs_idle("after_reset");

        // 2 beats of counting pattern, always ready
        ready_mode = 0;
        n_acc = 0;
        start_xfer(2);
        send_beats(2, 100, 2, 1'b1);
        wait_done(cyc);
        chk("t1_beats", 64'(n_acc), 2);

        // 20 beats with downstream stalled: buffer fills to 16, then drains
        ready_mode = 1;
        n_acc = 0;
        start_xfer(20);
        fork
            send_beats(20, 100, 20, 1'b0);
            begin
                repeat (40) @(posedge clk);
                #1;
                chk("t2_fill_count", 64'(n_acc), 16);
                chk("t2_full_ready", 64'(ddr_rd_ready), 0);
                out_ready = 1'b1;
                ready_mode = 0;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!ddr_rd_ready && n < 100);
                chk("t2_ready_return_cycles", 64'(n), 17);
            end
        join
        wait_done(cyc);
        chk("t2_beats", 64'(n_acc), 20);

        // 37 beats, random valid and ready
        ready_mode = 2;
        n_acc = 0;
        start_xfer(37);
        send_beats(37, 50, 37, 1'b0);
        wait_done(cyc);
        chk("t3_beats", 64'(n_acc), 37);

        // Zero-beat transfer, started in the previous done cycle
        ready_mode = 0;
        start_xfer(0);
        wait_done(cyc);
        chk("t4_zero_done_latency", 64'(cyc), 0);
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_idle("t4_after_zero");

        // Reset after 3 of 8 beats with data held in the buffer
        ready_mode = 1;
        n_acc = 0;
        start_xfer(8);
        send_beats(8, 100, 3, 1'b0);
        chk("t5_pre_reset_valid", 64'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_idle("t5_mid_reset");
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_xfer(1);
        send_beats(1, 100, 1, 1'b0);
        wait_done(cyc);

        // start pulsed during RUN is ignored; start in done cycle is taken
        ready_mode = 2;
        n_acc = 0;
        start_xfer(3);
        fork
            send_beats(3, 70, 3, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                beat_total = 16'd5;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        wait_done(cyc);
        chk("t6_beats", 64'(n_acc), 3);
        n_acc = 0;
        start_xfer(2);
        chk("t6_busy_after_done_start", 64'(busy), 1);
        send_beats(2, 100, 2, 1'b1);
        wait_done(cyc);
        chk("t6_second_beats", 64'(n_acc), 2);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pakage_unload.md
# pakage_unload

Read-side counterpart of the DDR write packager: accepts 512-bit read beats from the DDR controller into a small beat buffer and unpacks each beat into narrower words for the accelerator datapath. Sits between the DDR read-data channel and the compute input, with valid/ready flow control on both sides. A start/done pair brackets a transfer of a programmed beat count.

## Interface
- `DEPTH`, 16: beat buffer depth in 512-bit entries; power of two, ≥2.
- `OUT_W`, 32: output word width; must divide 512; `WPB = 512/OUT_W` words per beat.
- `clk` input 1: single clock, all logic rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; begins a transfer; honoured only in IDLE.
- `beat_total` input 16: beats in the transfer; sampled on accepted `start`.
- `ddr_rd_valid` input 1: DDR read beat valid.
- `ddr_rd_data` input 512: DDR read beat.
- `ddr_rd_ready` output 1: block accepts a beat this cycle.
- `out_valid` output 1: `out_data` holds a valid word.
- `out_data` output OUT_W: unpacked word.
- `out_last` output 1: current word is the final word of the transfer.
- `out_ready` input 1: downstream accepts word.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse at transfer completion.

## Operation
- FSM states IDLE, RUN. Reset → IDLE.
- IDLE: `start`=1 → latch `beat_total`, clear `wr_ptr`, `rd_ptr`, `count`, `word_idx`, `beats_in`, `beats_out`; go RUN. If `beat_total`=0 → stay IDLE, pulse `done` next cycle, no handshakes occur.
- RUN: `start` ignored.
- Beat accept when `ddr_rd_valid && ddr_rd_ready`: write `mem[wr_ptr]`, `wr_ptr` += 1 (wraps at DEPTH), `beats_in` += 1.
- `ddr_rd_ready` = RUN && `count` < DEPTH && `beats_in` < latched total; computed from registered `count` only (no same-cycle pass-through of a freed slot).
- `out_valid` = RUN && `count` ≠ 0. `out_data` = `mem[rd_ptr][word_idx*OUT_W +: OUT_W]`; word 0 is bits [OUT_W-1:0] (little-endian within beat).
- Word handshake (`out_valid && out_ready`): `word_idx` += 1; at `word_idx` = WPB-1 wrap to 0, `rd_ptr` += 1, `beats_out` += 1, entry freed.
- `count` (0..DEPTH, width log2(DEPTH)+1): +1 on beat accept, −1 on entry free, unchanged when both occur same cycle.
- `out_last` = `out_valid` && `word_idx` = WPB-1 && `beats_out` = total−1.
- Handshake on `out_last` word → next cycle `done`=1 for one cycle, state IDLE, `busy`=0.
- `out_data` holds stable while `out_valid && !out_ready`; buffer entry not overwritten until freed.
- Beats offered after `beats_in` reaches total are not accepted (ready low).

## Timing
- Reset values: `ddr_rd_ready`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0; `out_data` don't-care while `out_valid`=0 (drive 0 from reset-cleared mem read is not required).
- `start` accepted at edge N → `busy`=1 and `ddr_rd_ready`=1 from cycle N+1.
- Beat accepted at edge N into empty buffer → `out_valid`=1 cycle N+1, word 0 presented.
- Sustained throughput: one word per cycle with `out_ready`=1; input side one beat per WPB cycles sustained, bursts up to DEPTH beats at one per cycle.
- Full buffer: slot freed at edge N → `ddr_rd_ready`=1 from cycle N+1.
- `done` pulses in the cycle after the final word handshake; a new `start` is accepted in that same `done` cycle.
- `rst_n` asserted mid-transfer: immediate return to IDLE, all outputs to reset values, buffered data discarded, no `done`.

## Test plan
- DEPTH=16, OUT_W=32, `beat_total`=2, beats with word k = beat*16+k, `out_ready`=1 → 32 words 0..31 in order, `out_last` only on word 31, `done` one cycle later.
- `beat_total`=20, `out_ready`=0 → exactly 16 beats accepted, `ddr_rd_ready` low; raise `out_ready` → ready returns one cycle after first entry freed, all 320 words correct, `rd_ptr`/`wr_ptr` wrap verified.
- Random `ddr_rd_valid` and `out_ready` toggling, `beat_total`=37 → scoreboard matches 592 words, `out_data` stable under stall, no beat accepted beyond 37.
- `start` with `beat_total`=0 → `done` next cycle, `ddr_rd_ready` and `out_valid` never assert.
- `rst_n` low after 3 of 8 beats → outputs zero same cycle; after release and new `start` (`beat_total`=1) only new beat's 16 words appear.
- `start` pulsed during RUN → ignored, total unchanged; `start` in `done` cycle → new transfer begins.
